sample_buffer_ctrl: RTL and testbench
=====================================

SAMPLE_BUFFER_CTRL -- requirements
Module: sample_buffer_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning RAM address width; frame length N = 2^ADDR_W samples.
REQ-002 SHALL have parameter DATA_W, default 16, meaning sample width.
REQ-003 SHALL have port clk  input  1  single clock for all logic and the attached RAM.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_valid  input  1  upstream sample valid.
REQ-006 SHALL have port s_ready  output  1  block accepts the upstream sample.
REQ-007 SHALL have port s_data  input  DATA_W  upstream sample.
REQ-008 SHALL have port m_valid  output  1  downstream sample valid.
REQ-009 SHALL have port m_ready  input  1  downstream accepts the sample.
REQ-010 SHALL have port m_data  output  DATA_W  downstream sample.
REQ-011 SHALL have port m_last  output  1  marks the final sample of a frame, qualified by m_valid.
REQ-012 SHALL have port ram_ce, ram_wre, ram_oce, ram_reset  output  1 each  single-port BSRAM controls.
REQ-013 SHALL have port ram_ad  output  ADDR_W  BSRAM address.
REQ-014 SHALL have port ram_din  output  DATA_W  BSRAM write data.
REQ-015 SHALL have port ram_dout  input  DATA_W  BSRAM read data, valid one clk after the addressing edge (bypass read mode).

Function
REQ-016 SHALL implement two states: FILL and DRAIN; FILL after reset.
REQ-017 In FILL: s_ready=1 and m_valid=0; each s_valid&&s_ready cycle SHALL assert ram_ce=1, ram_wre=1, ram_ad=wr_cnt, ram_din=s_data, then increment wr_cnt.
REQ-018 On acceptance of the sample at wr_cnt=N-1, SHALL wrap wr_cnt to 0 and enter DRAIN next cycle.
REQ-019 In DRAIN: s_ready=0; ram_wre=0; reads SHALL be issued with ram_ce=1 at ram_ad=rd_addr(rd_cnt), rd_cnt 0..N-1.
REQ-020 A read SHALL be issued only when the output buffer (2 entries) has room counting reads in flight; no sample SHALL be lost or duplicated under any m_ready pattern.
REQ-021 With m_ready held 1: first m_valid 2 cycles after DRAIN entry, then one sample per cycle, N consecutive samples.
REQ-022 m_data/m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-023 m_last SHALL be 1 exactly on the sample from rd_cnt=N-1.
REQ-024 After the m_last handshake, SHALL return to FILL next cycle with rd_cnt=0; s_ready rises that cycle.
REQ-025 ram_oce SHALL be constant 1; ram_reset SHALL be constant 0; ram_ce=0 in cycles with no access.
REQ-026 Counters SHALL be ADDR_W bits, wrapping modulo N.

Reset
REQ-027 While rst_n=0: state=FILL, wr_cnt=0, rd_cnt=0, output buffer empty, s_ready=0, m_valid=0, m_last=0, m_data=0, ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0.
REQ-028 s_ready SHALL rise the first clk edge after rst_n deasserts.
REQ-029 Reset mid-frame (FILL or DRAIN) SHALL discard the partial frame; RAM contents are don't-care; next frame starts at address 0.

Configuration
REQ-030 Macro SAMPLE_BUFFER_BITREV_EN defined: rd_addr(rd_cnt)=bit-reverse of rd_cnt over ADDR_W bits (FFT input order); undefined: rd_addr(rd_cnt)=rd_cnt (natural order). Write order SHALL be natural in both cases.

Verification
REQ-031 ADDR_W=3, macro undefined, write 0..7 back-to-back, m_ready=1 -> m_data 0..7 on 8 consecutive cycles, m_last on 7, s_ready=0 during drain.
REQ-032 ADDR_W=3, macro defined, write 0..7 -> m_data 0,4,2,6,1,5,3,7, m_last on 7.
REQ-033 m_ready toggled pseudo-randomly (50%) during drain -> exactly 8 handshakes, correct order, data stable while stalled.
REQ-034 s_valid gapped (1 of 3 cycles) during fill -> ram_wre only on accepted cycles, addresses 0..7 contiguous.
REQ-035 rst_n asserted after 5 drain handshakes -> m_valid=0 immediately, s_ready=1 one cycle after release, next frame outputs from index 0.
REQ-036 Two frames back-to-back with m_ready=1 -> s_ready rises the cycle after the first frame's m_last, second frame output identical ordering.

Source files
------------

// File: rtl/sample_buffer_ctrl.sv
// Frame buffer controller: fills a single-port BSRAM with N=2^ADDR_W samples, then drains them through a 2-entry skid buffer.
// Build option: define SAMPLE_BUFFER_BITREV_EN for bit-reversed read order (FFT input); otherwise reads are in natural order.
module sample_buffer_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic              ram_oce,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  logic [0:0]        r_state;
  logic              r_s_ready;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic              r_rd_all;
  logic              r_inflight;
  logic              r_inflight_last;

  logic [DATA_W-1:0] r_buf_data [2];
  logic              r_buf_last [2];
  logic              r_buf_wptr;
  logic              r_buf_rptr;
  logic [1:0]        r_buf_cnt;

  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_occ;
  logic [ADDR_W-1:0] w_rd_addr;

`ifdef SAMPLE_BUFFER_BITREV_EN
  for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_bitrev
    assign w_rd_addr[gi] = r_rd_cnt[ADDR_W-1-gi];
  end
`else
  assign w_rd_addr = r_rd_cnt;
`endif

  assign m_valid = (r_buf_cnt != 2'd0);
  assign m_data  = r_buf_data[r_buf_rptr];
  assign m_last  = m_valid & r_buf_last[r_buf_rptr];
  assign s_ready = r_s_ready;

  assign w_wr_fire = (r_state == S_FILL) & s_valid & r_s_ready;
  assign w_pop     = m_valid & m_ready;
  assign w_push    = r_inflight;

  // Occupancy seen by a read issued now: buffered + in flight, minus the entry leaving this cycle.
  assign w_occ     = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_fire = (r_state == S_DRAIN) & ~r_rd_all & (w_occ < 3'd2);

  assign ram_ce    = w_wr_fire | w_rd_fire;
  assign ram_wre   = w_wr_fire;
  assign ram_ad    = (r_state == S_FILL) ? r_wr_cnt : w_rd_addr;
  assign ram_din   = w_wr_fire ? s_data : '0;
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FILL;
      r_s_ready <= 1'b0;
      r_wr_cnt  <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          r_s_ready <= 1'b1;
          if (w_wr_fire) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (r_wr_cnt == LAST_IDX) begin
              r_state   <= S_DRAIN;
              r_s_ready <= 1'b0;
            end
          end
        end
        default: begin
          r_s_ready <= 1'b0;
          if (w_pop && m_last) begin
            r_state   <= S_FILL;
            r_s_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt        <= '0;
      r_rd_all        <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_rd_fire;
      r_inflight_last <= w_rd_fire && (r_rd_cnt == LAST_IDX);
      if (w_rd_fire) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
        if (r_rd_cnt == LAST_IDX) begin
          r_rd_all <= 1'b1;
        end
      end
      if ((r_state == S_DRAIN) && w_pop && m_last) begin
        r_rd_cnt <= '0;
        r_rd_all <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_wptr <= 1'b0;
      r_buf_rptr <= 1'b0;
      r_buf_cnt  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_wptr <= ~r_buf_wptr;
      end
      if (w_pop) begin
        r_buf_rptr <= ~r_buf_rptr;
      end
      r_buf_cnt <= r_buf_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Read data lands one clock after its address, so capture straight from ram_dout.
  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_buf_data[gi] <= '0;
        r_buf_last[gi] <= 1'b0;
      end else if (w_push && (r_buf_wptr == 1'(gi))) begin
        r_buf_data[gi] <= ram_dout;
        r_buf_last[gi] <= r_inflight_last;
      end
    end
  end

endmodule

// File: tb/tb_sample_buffer_ctrl.sv
// Directed bench for sample_buffer_ctrl at ADDR_W=3 with a behavioural BSRAM; honours SAMPLE_BUFFER_BITREV_EN.
module tb_sample_buffer_ctrl;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          ram_ce;
  logic          ram_wre;
  logic          ram_oce;
  logic          ram_reset;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [8];
  int order [8];
  int checks;
  int failures;

  typedef struct {
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          exp_ce;
    logic          exp_wre;
    logic [AW-1:0] exp_ad;
  } fill_vec_t;

  sample_buffer_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_oce(ram_oce), .ram_reset(ram_reset),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      else         ram_dout    <= mem[ram_ad];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // gap = idle cycles inserted before each accepted sample
  task automatic run_fill(input int gap, input logic [DW-1:0] base);
    fill_vec_t vecs[$];
    fill_vec_t v;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        v.s_valid = 1'b0; v.s_data = 16'hDEAD; v.exp_ce = 1'b0; v.exp_wre = 1'b0; v.exp_ad = '0;
        vecs.push_back(v);
      end
      v.s_valid = 1'b1; v.s_data = base + 16'(i); v.exp_ce = 1'b1; v.exp_wre = 1'b1; v.exp_ad = AW'(i);
      vecs.push_back(v);
    end
    foreach (vecs[j]) begin
      s_valid = vecs[j].s_valid;
      s_data  = vecs[j].s_data;
      @(negedge clk);
      check("fill_s_ready", s_ready, 1);
      check("fill_m_valid", m_valid, 0);
      check("fill_ram_ce", ram_ce, vecs[j].exp_ce);
      check("fill_ram_wre", ram_wre, vecs[j].exp_wre);
      if (vecs[j].s_valid) begin
        check("fill_ram_ad", ram_ad, vecs[j].exp_ad);
        check("fill_ram_din", ram_din, vecs[j].s_data);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  // mode 0: m_ready held high; mode 1: m_ready random
  task automatic run_drain(input int mode, input logic [DW-1:0] base, input int stop_after);
    int k = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] exp_d;
    while (k < stop_after && cyc < 200) begin
      m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("drain_s_ready", s_ready, 0);
      check("drain_ram_wre", ram_wre, 0);
      if (mode == 0) check("drain_valid_timing", m_valid, (cyc >= 2) ? 1 : 0);
      if (stalled) begin
        check("stall_valid_held", m_valid, 1);
        check("stall_data_held", m_data, held);
      end
      if (m_valid) begin
        exp_d = base + 16'(order[k]);
        check("drain_data", m_data, exp_d);
        check("drain_last", m_last, (k == 7) ? 1 : 0);
        stalled = !m_ready;
        held    = m_data;
        if (m_ready) begin
          $display("xfer idx=%0d data=%04h last=%0d", k, m_data, m_last);
          k++;
        end
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_handshakes", k, stop_after);
    if (stop_after == 8) begin
      @(negedge clk);
      check("refill_s_ready", s_ready, 1);
      check("refill_m_valid", m_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
`ifdef SAMPLE_BUFFER_BITREV_EN
    order = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    order = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    checks = 0; failures = 0;
    clk = 1'b0; rst_n = 1'b0; s_valid = 1'b1; s_data = 16'h55AA; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_ram_ce", ram_ce, 0);
    check("rst_ram_wre", ram_wre, 0);
    check("rst_ram_ad", ram_ad, 0);
    check("rst_ram_din", ram_din, 0);
    check("ram_oce", ram_oce, 1);
    check("ram_reset", ram_reset, 0);

    @(posedge clk); #1;
    rst_n = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    check("s_ready_before_edge", s_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("s_ready_after_release", s_ready, 1);
    @(posedge clk); #1;

    run_fill(0, 16'h0100);
    run_drain(0, 16'h0100, 8);
    run_fill(0, 16'h0200);
    run_drain(0, 16'h0200, 8);
    run_fill(2, 16'h0300);
    run_drain(1, 16'h0300, 8);

    run_fill(0, 16'h0400);
    run_drain(0, 16'h0400, 5);
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_ram_ce", ram_ce, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_s_ready_before_edge", s_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_s_ready_after_release", s_ready, 1);
    @(posedge clk); #1;

    run_fill(0, 16'h0500);
    run_drain(0, 16'h0500, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
